// File: rtl/dut_io_burst_pack_if.sv
// Bus bundle for dut_io_burst_pack: word-serial write/read ports, commit/capture
// strobes, error flag and the wide DUT-facing vectors.
interface dut_io_burst_pack_if #(
    parameter int DUT_INPUT_WIDTH  = 256,
    parameter int DUT_OUTPUT_WIDTH = 256,
    parameter int WORD_WIDTH       = 32
);
    logic                        in_wr_en;
    logic                        in_wr_mode;
    logic [31:0]                 in_wr_addr;
    logic [WORD_WIDTH-1:0]       in_wr_data;
    logic                        in_commit;
    logic                        in_complete;
    logic [DUT_INPUT_WIDTH-1:0]  dut_input_vec_to_dut;
    logic [DUT_OUTPUT_WIDTH-1:0] dut_output_vec_from_dut;
    logic                        out_capture;
    logic                        out_rd_en;
    logic                        out_rd_mode;
    logic [31:0]                 out_rd_addr;
    logic [WORD_WIDTH-1:0]       out_rd_data;
    logic                        out_rd_valid;
    logic                        out_rd_last;
    logic                        err_addr;
    logic                        err_clr;

    modport slave (
        input  in_wr_en, in_wr_mode, in_wr_addr, in_wr_data, in_commit,
        input  dut_output_vec_from_dut, out_capture,
        input  out_rd_en, out_rd_mode, out_rd_addr, err_clr,
        output in_complete, dut_input_vec_to_dut,
        output out_rd_data, out_rd_valid, out_rd_last, err_addr
    );

    modport master (
        output in_wr_en, in_wr_mode, in_wr_addr, in_wr_data, in_commit,
        output dut_output_vec_from_dut, out_capture,
        output out_rd_en, out_rd_mode, out_rd_addr, err_clr,
        input  in_complete, dut_input_vec_to_dut,
        input  out_rd_data, out_rd_valid, out_rd_last, err_addr
    );
endinterface

// File: rtl/dut_io_burst_pack.sv
// Word-serial bridge between the register side and the DUT's wide I/O vectors.
// Define DUT_IO_BURST_SHADOW_EN for a committed shadow buffer; otherwise writes hit the DUT vector directly.
module dut_io_burst_pack #(
    parameter int DUT_INPUT_WIDTH  = 256,
    parameter int DUT_OUTPUT_WIDTH = 256,
    parameter int WORD_WIDTH       = 32
) (
    input logic                clk,
    input logic                reset,
    dut_io_burst_pack_if.slave bus
);
    localparam int IN_WORDS  = (DUT_INPUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int OUT_WORDS = (DUT_OUTPUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IN_PTR_W  = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int OUT_PTR_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    typedef logic [IN_PTR_W-1:0]  in_ptr_t;
    typedef logic [OUT_PTR_W-1:0] out_ptr_t;

    function automatic in_ptr_t in_ptr_next(input in_ptr_t p);
        return (p == in_ptr_t'(IN_WORDS - 1)) ? '0 : p + in_ptr_t'(1);
    endfunction

    function automatic out_ptr_t out_ptr_next(input out_ptr_t p);
        return (p == out_ptr_t'(OUT_WORDS - 1)) ? '0 : p + out_ptr_t'(1);
    endfunction

    // ---------------- input (write) side ----------------
    logic [DUT_INPUT_WIDTH-1:0] vec_q, vec_d;
    logic [DUT_INPUT_WIDTH-1:0] img_base, img_wr;
    logic [IN_WORDS-1:0]        mask_q, mask_d;
    in_ptr_t                    wp_q, wp_d;
    in_ptr_t                    wr_idx;
    logic                       wr_oob, wr_accept;

    assign wr_oob    = bus.in_wr_en && !bus.in_wr_mode
                       && (bus.in_wr_addr >= 32'(IN_WORDS));
    assign wr_accept = bus.in_wr_en && !wr_oob;
    assign wr_idx    = bus.in_wr_mode ? wp_q : bus.in_wr_addr[IN_PTR_W-1:0];

    // Per-word merge; the last word is clipped so bits beyond the vector are dropped.
    for (genvar k = 0; k < IN_WORDS; k++) begin : g_wr_word
        localparam int LO = k * WORD_WIDTH;
        localparam int HI = (LO + WORD_WIDTH > DUT_INPUT_WIDTH) ? DUT_INPUT_WIDTH
                                                                 : LO + WORD_WIDTH;
        assign img_wr[HI-1:LO] = (wr_accept && wr_idx == in_ptr_t'(k))
                                 ? bus.in_wr_data[HI-LO-1:0]
                                 : img_base[HI-1:LO];
    end

`ifdef DUT_IO_BURST_SHADOW_EN
    logic [DUT_INPUT_WIDTH-1:0] shadow_q;

    assign img_base = shadow_q;
    // A concurrent write is already merged into img_wr, so a same-cycle commit carries it.
    assign vec_d    = bus.in_commit ? img_wr : vec_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= img_wr;
        end
    end
`else
    assign img_base = vec_q;
    assign vec_d    = img_wr;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wp_d   = wp_q;
        mask_d = mask_q;
        if (wr_accept) begin
            mask_d[wr_idx] = 1'b1;
            wp_d           = in_ptr_next(wr_idx);
        end
        if (bus.in_commit) begin
            wp_d   = '0;
            mask_d = '0;
        end
    end

    // ---------------- output (read) side ----------------
    logic [DUT_OUTPUT_WIDTH-1:0] cap_q, cap_d;
    logic [WORD_WIDTH-1:0]       cap_word [OUT_WORDS];
    logic [WORD_WIDTH-1:0]       rd_data_q, rd_data_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_last_q, rd_last_d;
    out_ptr_t                    rp_q, rp_d;
    out_ptr_t                    rd_idx;
    logic                        rd_oob;

    // Padding above the output vector reads back as zero.
    for (genvar k = 0; k < OUT_WORDS; k++) begin : g_rd_word
        localparam int LO = k * WORD_WIDTH;
        localparam int HI = (LO + WORD_WIDTH > DUT_OUTPUT_WIDTH) ? DUT_OUTPUT_WIDTH
                                                                  : LO + WORD_WIDTH;
        assign cap_word[k] = WORD_WIDTH'(cap_q[HI-1:LO]);
    end

    assign rd_oob = bus.out_rd_en && !bus.out_rd_mode
                    && (bus.out_rd_addr >= 32'(OUT_WORDS));
    assign rd_idx = bus.out_rd_mode ? rp_q : bus.out_rd_addr[OUT_PTR_W-1:0];

    always_comb begin
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        rp_d       = rp_q;
        cap_d      = cap_q;
        if (bus.out_rd_en) begin
            rd_valid_d = 1'b1;
            if (rd_oob) begin
                rd_data_d = '0;
            end else begin
                rd_data_d = cap_word[rd_idx];
                rd_last_d = (rd_idx == out_ptr_t'(OUT_WORDS - 1));
                rp_d      = out_ptr_next(rd_idx);
            end
        end
        // Capture overrides the read's pointer advance; the read itself saw the old snapshot.
        if (bus.out_capture) begin
            cap_d = bus.dut_output_vec_from_dut;
            rp_d  = '0;
        end
    end

    // ---------------- error flag ----------------
    logic err_q, err_d;

    assign err_d = (wr_oob || rd_oob) ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);

    // ---------------- state ----------------
    // NOTE: the wide vector and snapshot buffers are reset too, so reset-time reads are defined zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_q      <= '0;
            mask_q     <= '0;
            wp_q       <= '0;
            cap_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rp_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            vec_q      <= vec_d;
            mask_q     <= mask_d;
            wp_q       <= wp_d;
            cap_q      <= cap_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rp_q       <= rp_d;
            err_q      <= err_d;
        end
    end

    assign bus.dut_input_vec_to_dut = vec_q;
    assign bus.in_complete          = &mask_q;
    assign bus.out_rd_data          = rd_data_q;
    assign bus.out_rd_valid         = rd_valid_q;
    assign bus.out_rd_last          = rd_last_q;
    assign bus.err_addr             = err_q;

endmodule

// File: tb/tb_dut_io_burst_pack.sv
// Directed bench for dut_io_burst_pack at 72/72-bit vectors, 32-bit words.
// Expectations follow DUT_IO_BURST_SHADOW_EN when it is defined for the build.
module tb_dut_io_burst_pack;
    localparam int DIW = 72;
    localparam int DOW = 72;
    localparam int WW  = 32;

`ifdef DUT_IO_BURST_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    dut_io_burst_pack_if #(.DUT_INPUT_WIDTH(DIW), .DUT_OUTPUT_WIDTH(DOW), .WORD_WIDTH(WW)) bus ();

    dut_io_burst_pack #(
        .DUT_INPUT_WIDTH (DIW),
        .DUT_OUTPUT_WIDTH(DOW),
        .WORD_WIDTH      (WW)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_wr_en    = 1'b0;
        bus.in_commit   = 1'b0;
        bus.out_capture = 1'b0;
        bus.out_rd_en   = 1'b0;
        bus.err_clr     = 1'b0;
    endtask

    task automatic wr(input logic mode, input logic [31:0] addr, input logic [31:0] data);
        bus.in_wr_en   = 1'b1;
        bus.in_wr_mode = mode;
        bus.in_wr_addr = addr;
        bus.in_wr_data = data;
        tick();
        idle();
    endtask

    task automatic rd(input logic mode, input logic [31:0] addr);
        bus.out_rd_en   = 1'b1;
        bus.out_rd_mode = mode;
        bus.out_rd_addr = addr;
        tick();
        idle();
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] data, input logic last);
        check({tag, "_data"},  bus.out_rd_data,  data);
        check({tag, "_valid"}, bus.out_rd_valid, 1'b1);
        check({tag, "_last"},  bus.out_rd_last,  last);
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_vec"},   bus.dut_input_vec_to_dut, '0);
        check({tag, "_cmpl"},  bus.in_complete,  1'b0);
        check({tag, "_err"},   bus.err_addr,     1'b0);
        check({tag, "_valid"}, bus.out_rd_valid, 1'b0);
        check({tag, "_last"},  bus.out_rd_last,  1'b0);
        check({tag, "_data"},  bus.out_rd_data,  '0);
    endtask

    initial begin
        idle();
        bus.in_wr_mode              = 1'b0;
        bus.in_wr_addr              = '0;
        bus.in_wr_data              = '0;
        bus.out_rd_mode             = 1'b0;
        bus.out_rd_addr             = '0;
        bus.dut_output_vec_from_dut = '0;
        reset = 1'b0;
        #22;
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Auto-increment burst of three words.
        wr(1'b1, 32'd0, 32'h1111_1111);
        check("wr1_vec", bus.dut_input_vec_to_dut, SHADOW ? 72'h0 : 72'h11111111);
        wr(1'b1, 32'd0, 32'h2222_2222);
        wr(1'b1, 32'd0, 32'hFFFF_FFFF);
        check("burst_cmpl", bus.in_complete, 1'b1);
        check("burst_vec", bus.dut_input_vec_to_dut,
              SHADOW ? 72'h0 : 72'hFF_22222222_11111111);

        bus.in_commit = 1'b1;
        tick();
        idle();
        check("commit_vec",  bus.dut_input_vec_to_dut, 72'hFF_22222222_11111111);
        check("commit_cmpl", bus.in_complete, 1'b0);

        // Addressed write resumes the burst: index 1, then 2, then wrap to 0.
        wr(1'b0, 32'd1, 32'hAAAA_5555);
        wr(1'b1, 32'd0, 32'h3333_3333);
        wr(1'b1, 32'd0, 32'h4444_4444);
        check("resume_cmpl", bus.in_complete, 1'b1);
        check("resume_vec", bus.dut_input_vec_to_dut,
              SHADOW ? 72'hFF_22222222_11111111 : 72'h33_AAAA5555_44444444);

        // Out-of-range write dropped; error flag and its clear.
        wr(1'b0, 32'd3, 32'hDEAD_BEEF);
        check("oob_wr_err", bus.err_addr, 1'b1);
        bus.err_clr = 1'b1;
        bus.in_wr_en = 1'b1;
        bus.in_wr_mode = 1'b0;
        bus.in_wr_addr = 32'd7;
        tick();
        idle();
        check("err_clr_vs_new", bus.err_addr, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        idle();
        check("err_clr", bus.err_addr, 1'b0);

        // wp was left at 1 by the wrap; the dropped writes must not have moved it.
        wr(1'b1, 32'd0, 32'h5555_5555);
        bus.in_commit = 1'b1;
        tick();
        idle();
        check("wp_kept_vec", bus.dut_input_vec_to_dut, 72'h33_55555555_44444444);

        // Capture and read back word-serially.
        bus.dut_output_vec_from_dut = 72'h12_34567890_ABCDEF01;
        bus.out_capture = 1'b1;
        tick();
        idle();
        bus.out_rd_en   = 1'b1;
        bus.out_rd_mode = 1'b1;
        tick();
        chk_rd("rd0", 32'hABCD_EF01, 1'b0);
        tick();
        chk_rd("rd1", 32'h3456_7890, 1'b0);
        tick();
        chk_rd("rd2", 32'h0000_0012, 1'b1);
        idle();
        tick();
        check("rd_idle_valid", bus.out_rd_valid, 1'b0);
        check("rd_idle_hold",  bus.out_rd_data, 32'h0000_0012);

        // Read concurrent with capture returns the old snapshot; rp resets.
        rd(1'b1, 32'd0);
        chk_rd("pre_cap", 32'hABCD_EF01, 1'b0);
        bus.dut_output_vec_from_dut = 72'h99_88888888_77777777;
        bus.out_capture = 1'b1;
        bus.out_rd_en   = 1'b1;
        bus.out_rd_mode = 1'b1;
        tick();
        idle();
        chk_rd("cap_rd_old", 32'h3456_7890, 1'b0);
        rd(1'b1, 32'd0);
        chk_rd("cap_rd_new", 32'h7777_7777, 1'b0);

        // Addressed reads: out of range, then last word.
        rd(1'b0, 32'd5);
        chk_rd("oob_rd", 32'h0, 1'b0);
        check("oob_rd_err", bus.err_addr, 1'b1);
        rd(1'b0, 32'd2);
        chk_rd("addr_rd2", 32'h0000_0099, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        idle();

        // Write and commit in the same cycle.
        bus.in_wr_en   = 1'b1;
        bus.in_wr_mode = 1'b1;
        bus.in_wr_data = 32'hCAFE_F00D;
        bus.in_commit  = 1'b1;
        tick();
        idle();
        check("wrcommit_vec",  bus.dut_input_vec_to_dut, 72'h33_55555555_CAFEF00D);
        check("wrcommit_cmpl", bus.in_complete, 1'b0);

        // Reset mid-burst clears everything immediately.
        wr(1'b1, 32'd0, 32'h0BAD_0BAD);
        rd(1'b1, 32'd0);
        reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        #2;
        reset = 1'b1;
        tick();
        check("post_reset_vec", bus.dut_input_vec_to_dut, 72'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
